dino_motion_ctrl: RTL and testbench

Per-frame dino motion controller that sits directly upstream of the sprite renderer. It samples the player's jump and duck requests and integrates a simple ballistic jump once per video frame. It produces the dino's vertical position and sprite selection (run/jump/duck), which the renderer consumes in place of host register writes. Updates are frame-synchronous: they occur only at the start of vertical blank, so a position never changes mid-scan.

---
 rtl/dino_pkg.sv | 26 ++
 rtl/dino_motion_ctrl_frame_tick_gen.sv | 28 ++
 rtl/dino_motion_ctrl.sv | 125 ++++++++++++
 tb/tb_dino_motion_ctrl.sv | 295 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dino_pkg.sv
// dino_pkg: motion state type, sprite codes and the shared vblank line.
// Imported by the dino motion controller and the renderer.
package dino_pkg;

    typedef enum logic [1:0] {
        RUN  = 2'd0,
        DUCK = 2'd1,
        AIR  = 2'd2
    } motion_t;

    localparam logic [1:0] SPR_RUN  = 2'd0;
    localparam logic [1:0] SPR_JUMP = 2'd1;
    localparam logic [1:0] SPR_DUCK = 2'd2;

    localparam logic [9:0] VBLANK_LINE = 10'd480;

    function automatic logic [1:0] spr_of(input motion_t s);
        case (s)
            RUN:     spr_of = SPR_RUN;
            AIR:     spr_of = SPR_JUMP;
            DUCK:    spr_of = SPR_DUCK;
            default: spr_of = SPR_RUN;
        endcase
    endfunction

endpackage

// File: rtl/dino_motion_ctrl_frame_tick_gen.sv
// frame_tick_gen: one-cycle registered pulse on entry to the vblank line.
// Ports: i_clk, i_reset (sync, high), i_vcount[9:0] -> o_tick.
module frame_tick_gen #(
    parameter logic [9:0] VBLANK_LINE = 10'd480
) (
    input  logic       i_clk,
    input  logic       i_reset,
    input  logic [9:0] i_vcount,
    output logic       o_tick
);

    logic [9:0] r_prev;
    logic       r_tick;

    // vcount holds for a whole line, so only the first cycle on it fires
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_prev <= '0;
            r_tick <= 1'b0;
        end else begin
            r_prev <= i_vcount;
            r_tick <= (i_vcount == VBLANK_LINE) && (r_prev != VBLANK_LINE);
        end
    end

    assign o_tick = r_tick;

endmodule

// File: rtl/dino_motion_ctrl.sv
// dino_motion_ctrl: frame-synchronous jump/duck motion for the dino sprite.
// Ports: clk, reset (sync, high), vcount[9:0], enable, jump_req, duck_req
//        -> dino_y[7:0], sprite_sel[1:0], airborne, frame_tick, landed.
module dino_motion_ctrl #(
    parameter logic [7:0] GROUND_Y    = 8'd100,
    parameter logic [5:0] JUMP_V0     = 6'd12,
    parameter logic [5:0] GRAVITY     = 6'd1,
    parameter logic [9:0] VBLANK_LINE = dino_pkg::VBLANK_LINE
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [9:0] vcount,
    input  logic       enable,
    input  logic       jump_req,
    input  logic       duck_req,
    output logic [7:0] dino_y,
    output logic [1:0] sprite_sel,
    output logic       airborne,
    output logic       frame_tick,
    output logic       landed
);

    import dino_pkg::*;

    logic               w_tick;
    logic               w_jump;
    logic signed [6:0]  w_fall;
    logic signed [9:0]  w_y_air;
    logic [9:0]         w_y_clamp;
    motion_t            w_state_n;
    logic signed [6:0]  w_vel_n;
    logic [7:0]         w_y_n;
    logic               w_land_n;

    motion_t            r_state;
    logic signed [6:0]  r_vel;
    logic [7:0]         r_y;
    logic               r_jump_pend;
    logic               r_landed;
    logic [1:0]         r_spr;
    logic               r_air;

    frame_tick_gen #(
        .VBLANK_LINE(VBLANK_LINE)
    ) u_tick (
        .i_clk    (clk),
        .i_reset  (reset),
        .i_vcount (vcount),
        .o_tick   (w_tick)
    );

    always_comb begin
        // a request in the tick cycle itself still counts for that tick
        w_jump    = r_jump_pend | jump_req;
        w_fall    = duck_req ? signed'({GRAVITY, 1'b0})
                             : signed'({1'b0, GRAVITY});
        w_y_air   = signed'({2'b00, r_y})
                  - signed'({{3{r_vel[6]}}, r_vel});
        w_y_clamp = w_y_air[9] ? 10'd0 : unsigned'(w_y_air);
        w_state_n = r_state;
        w_vel_n   = r_vel;
        w_y_n     = r_y;
        w_land_n  = 1'b0;
        unique case (r_state)
            RUN, DUCK: begin
                if (w_jump) begin
                    w_state_n = AIR;
                    w_vel_n   = signed'({1'b0, JUMP_V0});
                end else begin
                    w_state_n = duck_req ? DUCK : RUN;
                    w_y_n     = GROUND_Y;
                end
            end
            AIR: begin
                if (w_y_clamp >= {2'b00, GROUND_Y}) begin
                    w_state_n = RUN;
                    w_vel_n   = '0;
                    w_y_n     = GROUND_Y;
                    w_land_n  = 1'b1;
                end else begin
                    w_y_n   = w_y_clamp[7:0];
                    w_vel_n = r_vel - w_fall;
                end
            end
            default: begin
                w_state_n = RUN;
                w_vel_n   = '0;
                w_y_n     = GROUND_Y;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= RUN;
            r_vel       <= '0;
            r_y         <= GROUND_Y;
            r_jump_pend <= 1'b0;
            r_landed    <= 1'b0;
            r_spr       <= SPR_RUN;
            r_air       <= 1'b0;
        end else begin
            r_landed <= 1'b0;
            if (w_tick && enable) begin
                // pending jump is spent on every live tick, even in AIR
                r_jump_pend <= 1'b0;
                r_state     <= w_state_n;
                r_vel       <= w_vel_n;
                r_y         <= w_y_n;
                r_landed    <= w_land_n;
                r_spr       <= spr_of(w_state_n);
                r_air       <= (w_state_n == AIR);
            end else if (jump_req) begin
                r_jump_pend <= 1'b1;
            end
        end
    end

    assign dino_y     = r_y;
    assign sprite_sel = r_spr;
    assign airborne   = r_air;
    assign frame_tick = w_tick;
    assign landed     = r_landed;

endmodule

// File: tb/tb_dino_motion_ctrl.sv
// tb_dino_motion_ctrl: frame-level model plus directed jump/duck scenarios.
// Two instances share stimulus: default ground and a low ground/high jump.
module tb_dino_motion_ctrl;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       enable = 1'b1;
    logic       jump_req = 1'b0;
    logic       duck_req = 1'b0;
    logic [9:0] vcount = 10'd0;

    logic [7:0] y0, y1;
    logic [1:0] s0, s1;
    logic       a0, a1, t0, t1, l0, l1;

    always #5 clk = ~clk;

    dino_motion_ctrl u0 (
        .clk(clk), .reset(reset), .vcount(vcount), .enable(enable),
        .jump_req(jump_req), .duck_req(duck_req),
        .dino_y(y0), .sprite_sel(s0), .airborne(a0),
        .frame_tick(t0), .landed(l0)
    );

    dino_motion_ctrl #(
        .GROUND_Y(8'd10), .JUMP_V0(6'd31)
    ) u1 (
        .clk(clk), .reset(reset), .vcount(vcount), .enable(enable),
        .jump_req(jump_req), .duck_req(duck_req),
        .dino_y(y1), .sprite_sel(s1), .airborne(a1),
        .frame_tick(t1), .landed(l1)
    );

    int n_vec = 0;
    int n_err = 0;
    bit chk_en = 0;
    int n_ticks = 0;
    int n_land0 = 0;
    int ymin1 = 255;
    int ymax1 = 0;

    task automatic check(input string nm, input logic [31:0] act,
                         input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    // model: mode 0 run, 1 air, 2 duck (matches sprite code)
    int G[2]  = '{100, 10};
    int V0[2] = '{12, 31};
    int m_y[2], m_vel[2], m_mode[2], m_pend[2], m_land[2];
    int m_tick = 0;
    int m_prev = 0;
    int m_ny;
    bit m_jmp;

    initial forever begin
        @(posedge clk);
        if (reset) begin
            m_prev = 0;
            m_tick = 0;
            for (int k = 0; k < 2; k++) begin
                m_y[k] = G[k]; m_vel[k] = 0; m_mode[k] = 0;
                m_pend[k] = 0; m_land[k] = 0;
            end
        end else begin
            for (int k = 0; k < 2; k++) begin
                m_land[k] = 0;
                if (m_tick != 0 && enable) begin
                    m_jmp = (m_pend[k] != 0) || jump_req;
                    m_pend[k] = 0;
                    if (m_mode[k] != 1) begin
                        if (m_jmp) begin
                            m_mode[k] = 1;
                            m_vel[k] = V0[k];
                        end else begin
                            m_mode[k] = duck_req ? 2 : 0;
                            m_y[k] = G[k];
                        end
                    end else begin
                        m_ny = m_y[k] - m_vel[k];
                        if (m_ny < 0) m_ny = 0;
                        if (m_ny >= G[k]) begin
                            m_y[k] = G[k]; m_vel[k] = 0;
                            m_mode[k] = 0; m_land[k] = 1;
                        end else begin
                            m_y[k] = m_ny;
                            m_vel[k] = m_vel[k] - (duck_req ? 2 : 1);
                        end
                    end
                end else if (jump_req) begin
                    m_pend[k] = 1;
                end
            end
            m_tick = (vcount == 10'd480 && m_prev != 480) ? 1 : 0;
            m_prev = int'(vcount);
        end
    end

    initial forever begin
        @(negedge clk);
        if (chk_en) begin
            check("y0", y0, m_y[0]);
            check("spr0", s0, m_mode[0]);
            check("air0", a0, m_mode[0] == 1);
            check("tick0", t0, m_tick);
            check("land0", l0, m_land[0]);
            check("y1", y1, m_y[1]);
            check("spr1", s1, m_mode[1]);
            check("air1", a1, m_mode[1] == 1);
            check("tick1", t1, m_tick);
            check("land1", l1, m_land[1]);
            if (t0 === 1'b1) n_ticks++;
            if (l0 === 1'b1) n_land0++;
            if (int'(y1) < ymin1) ymin1 = int'(y1);
            if (int'(y1) > ymax1) ymax1 = int'(y1);
        end
    end

    task automatic frame(input int first, input int last, input int cpl);
        for (int v = first; v <= last; v++)
            for (int c = 0; c < cpl; c++) begin
                @(negedge clk);
                vcount = 10'(v);
            end
    endtask

    task automatic frame_s();
        frame(476, 483, 2);
    endtask

    task automatic jpulse();
        @(negedge clk);
        jump_req = 1'b1;
        @(negedge clk);
        jump_req = 1'b0;
    endtask

    int k, k1, base, lb;

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        @(posedge clk);
        #1 chk_en = 1;
        repeat (2) @(negedge clk);
        check("rst_y0", y0, 100);
        check("rst_spr0", s0, 0);
        check("rst_air0", a0, 0);
        check("rst_y1", y1, 10);
        reset = 1'b0;

        base = n_ticks;
        repeat (3) frame(0, 524, 2);
        check("ticks_3frames", n_ticks - base, 3);
        check("idle_y", y0, 100);
        check("idle_spr", s0, 0);

        // plain jump
        jpulse();
        frame_s();
        check("to_air", a0, 1);
        check("to_y", y0, 100);
        check("to_spr", s0, 1);
        frame_s(); check("f1_y", y0, 88);
        frame_s(); check("f2_y", y0, 77);
        frame_s(); check("f3_y", y0, 67);
        k = 3;
        lb = n_land0;
        while (a0 === 1'b1 && k < 40) begin
            frame_s();
            k++;
            if (k == 12) check("apex_y", y0, 22);
        end
        check("land_frame", k, 25);
        check("land_y", y0, 100);
        check("land_spr", s0, 0);
        check("land_cnt", n_land0 - lb, 1);
        k1 = k;
        while (a1 === 1'b1 && k1 < 60) begin
            frame_s();
            k1++;
        end
        check("clamp_land_frame", k1, 36);
        check("clamp_land_y", y1, 10);

        // duck, then ducking jump with fast fall
        @(negedge clk);
        duck_req = 1'b1;
        frame_s();
        check("duck_spr", s0, 2);
        check("duck_y", y0, 100);
        jpulse();
        frame_s();
        check("djump_spr", s0, 1);
        k = 0;
        while (a0 === 1'b1 && k < 40) begin
            frame_s();
            k++;
        end
        check("duck_land_frame", k, 13);
        check("duck_land_spr", s0, 0);
        k1 = 0;
        while (a1 === 1'b1 && k1 < 60) begin
            frame_s();
            k1++;
        end
        frame_s();
        check("reduck_spr", s0, 2);
        @(negedge clk);
        duck_req = 1'b0;
        frame_s();
        check("unduck_spr", s0, 0);

        // reset at apex, then jump on release
        jpulse();
        frame_s();
        repeat (12) frame_s();
        check("apex2_y", y0, 22);
        lb = n_land0;
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        check("rst_air_y", y0, 100);
        check("rst_air_spr", s0, 0);
        check("rst_air_land", l0, 0);
        reset = 1'b0;
        jump_req = 1'b1;
        @(negedge clk);
        jump_req = 1'b0;
        frame_s();
        check("rel_jump_air", a0, 1);
        check("rel_jump_y", y0, 100);
        k = 0;
        while (a0 === 1'b1 && k < 40) begin
            frame_s();
            k++;
        end
        check("rel_land_frame", k, 25);
        check("rel_land_cnt", n_land0 - lb, 1);
        k1 = 0;
        while (a1 === 1'b1 && k1 < 60) begin
            frame_s();
            k1++;
        end

        // freeze while airborne
        jpulse();
        frame_s();
        frame_s();
        frame_s();
        check("pre_frz_y", y0, 77);
        @(negedge clk);
        enable = 1'b0;
        jpulse();
        base = n_ticks;
        repeat (5) frame_s();
        check("frz_y", y0, 77);
        check("frz_spr", s0, 1);
        check("frz_ticks", n_ticks - base, 5);
        @(negedge clk);
        enable = 1'b1;
        frame_s();
        check("resume_y", y0, 67);
        k = 3;
        while (a0 === 1'b1 && k < 40) begin
            frame_s();
            k++;
        end
        check("frz_land_frame", k, 25);
        frame_s();
        check("no_dbl_jump", a0, 0);
        k1 = 0;
        while (a1 === 1'b1 && k1 < 60) begin
            frame_s();
            k1++;
        end
        frame_s();

        check("clamp_min_y", ymin1, 0);
        check("clamp_max_y", ymax1, 10);

        chk_en = 0;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
